// File: rtl/tick_countdown.sv
// Tick-driven countdown: loads a tick count on start, decrements on each upstream
// tick while running, pulses done on expiry and optionally reloads the last count.
module tick_countdown #(
    parameter int WIDTH       = 8,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    output logic             timer_enable,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_next;
    logic [WIDTH-1:0] remaining_next;
    logic [WIDTH-1:0] reload_value, reload_next;
    logic             done_next;

    // Priority is encoded by the if/else order: stop, start, pause, then tick.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next     = state;
        remaining_next = remaining;
        reload_next    = reload_value;
        done_next      = 1'b0;

        if (stop) begin
            state_next     = IDLE;
            remaining_next = '0;
        end else if (start) begin
            reload_next = load_value;
            if (load_value != '0) begin
                state_next     = RUN;
                remaining_next = load_value;
            end else begin
                state_next     = IDLE;
                remaining_next = '0;
                done_next      = 1'b1;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (pause) begin
                        state_next = PAUSED;
                    end else if (tick) begin
                        if (remaining > ONE) begin
                            remaining_next = remaining - ONE;
                        end else if (remaining == ONE) begin
                            done_next = 1'b1;
                            if (AUTO_RELOAD) begin
                                remaining_next = reload_value;
                            end else begin
                                remaining_next = '0;
                                state_next     = IDLE;
                            end
                        end
                    end
                end
                PAUSED: begin
                    if (!pause) state_next = RUN;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            reload_value <= '0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            remaining    <= remaining_next;
            reload_value <= reload_next;
            done         <= done_next;
        end
    end

    assign busy         = (state != IDLE);
    assign timer_enable = (state == RUN);

endmodule

// File: tb/tb_tick_countdown.sv
// Scoreboard bench for tick_countdown: two instances (stop-at-expiry and auto-reload)
// share random and directed stimulus and are compared against a behavioural model.
module tb_tick_countdown;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, stop, pause, tick;
    logic [W-1:0] load_value;

    logic         te0, busy0, done0, te1, busy1, done1;
    logic [W-1:0] rem0, rem1;

    always #5 clk = ~clk;

    tick_countdown #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_stop (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .load_value(load_value), .tick(tick),
        .timer_enable(te0), .remaining(rem0), .busy(busy0), .done(done0)
    );

    tick_countdown #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_reload (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .load_value(load_value), .tick(tick),
        .timer_enable(te1), .remaining(rem1), .busy(busy1), .done(done1)
    );

    // Model mode: 0 = idle, 1 = counting, 2 = paused.
    typedef struct {
        int           mode;
        int           rem;
        int           reload;
        bit           done;
    } model_t;

    typedef struct {
        int rem0; bit busy0; bit te0; bit done0;
        int rem1; bit busy1; bit te1; bit done1;
    } exp_t;

    exp_t   exp_q[$];
    model_t m0, m1;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic model_t advance(input model_t m, input bit ar, input bit r,
                                       input bit st, input bit sp, input bit pa,
                                       input bit tk, input int lv);
        model_t n;
        n      = m;
        n.done = 1'b0;
        if (r) begin
            n.mode = 0; n.rem = 0; n.reload = 0;
        end else if (sp) begin
            n.mode = 0; n.rem = 0;
        end else if (st) begin
            n.reload = lv;
            if (lv != 0) begin
                n.mode = 1; n.rem = lv;
            end else begin
                n.mode = 0; n.rem = 0; n.done = 1'b1;
            end
        end else if (m.mode == 1 && pa) begin
            n.mode = 2;
        end else if (m.mode == 2) begin
            if (!pa) n.mode = 1;
        end else if (m.mode == 1 && tk) begin
            if (m.rem == 1) begin
                n.done = 1'b1;
                if (ar) n.rem = m.reload;
                else begin n.rem = 0; n.mode = 0; end
            end else begin
                n.rem = m.rem - 1;
            end
        end
        return n;
    endfunction

    // Drive one cycle of stimulus and queue the response expected after the next edge.
    task automatic step(input bit r, input bit st, input bit sp, input bit pa,
                        input bit tk, input int lv);
        exp_t e;
        @(negedge clk);
        #1;
        rst = r; start = st; stop = sp; pause = pa; tick = tk; load_value = W'(lv);
        m0 = advance(m0, 1'b0, r, st, sp, pa, tk, lv);
        m1 = advance(m1, 1'b1, r, st, sp, pa, tk, lv);
        e.rem0 = m0.rem; e.busy0 = (m0.mode != 0); e.te0 = (m0.mode == 1); e.done0 = m0.done;
        e.rem1 = m1.rem; e.busy1 = (m1.mode != 0); e.te1 = (m1.mode == 1); e.done1 = m1.done;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit pa = 1'b0);
        for (int i = 0; i < n; i++) step(0, 0, 0, pa, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("remaining0", int'(rem0), e.rem0);
                check("busy0", int'(busy0), int'(e.busy0));
                check("timer_enable0", int'(te0), int'(e.te0));
                check("done0", int'(done0), int'(e.done0));
                check("remaining1", int'(rem1), e.rem1);
                check("busy1", int'(busy1), int'(e.busy1));
                check("timer_enable1", int'(te1), int'(e.te1));
                check("done1", int'(done1), int'(e.done1));
            end
        end
    end

    initial begin : driver
        int r;
        bit st, sp, pa, tk;
        int lv;
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; tick = 1'b0; load_value = '0;
        m0 = '{0, 0, 0, 1'b0};
        m1 = '{0, 0, 0, 1'b0};

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(2);

        // Basic count of 3 with ticks every fifth cycle.
        step(0, 1, 0, 0, 0, 3);
        for (int i = 1; i <= 15; i++) step(0, 0, 0, 0, (i % 5 == 0), 0);
        idle(3);

        // Pause holds the count and drops timer_enable; ticks while paused are ignored.
        step(0, 1, 0, 0, 0, 4);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, (i == 3 || i == 7), 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1, 0);
            idle(1);
        end
        idle(2);

        // Restart with a same-cycle tick, then abort.
        step(0, 1, 0, 0, 0, 5);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 2);
        step(0, 0, 1, 0, 1, 0);
        idle(20);

        // Zero load: immediate done, never busy.
        step(0, 1, 0, 0, 0, 0);
        idle(3);

        // Reload behaviour: six ticks on a count of 2.
        step(0, 1, 0, 0, 0, 2);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        idle(2);

        // Reset mid-count at remaining = 7.
        step(0, 1, 0, 0, 0, 9);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        idle(2);
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        idle(2);

        // Full-width load, stopped partway.
        step(0, 1, 0, 0, 0, 255);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);

        // Random traffic with rare control events and small counts.
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 99));
            sp = (r < 2);
            st = (r >= 2 && r < 8);
            pa = ($urandom_range(0, 9) < 2);
            tk = ($urandom_range(0, 2) == 0);
            lv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            if ($urandom_range(0, 49) == 0) lv = 255;
            step(($urandom_range(0, 499) == 0), st, sp, pa, tk, lv);
        end
        idle(2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
